// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the decode/write-back stage.
// Instruction codes, register IDs and the processor status enum.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  typedef enum logic [2:0] {
    SAOK = 3'd1,
    SHLT = 3'd2,
    SINS = 3'd4
  } stat_e;

endpackage

// File: rtl/decode_writeback_if.sv
// Instruction/operand bundle between the SEQ datapath and the decode/write-back stage.
// The stage itself uses the slave modport; the datapath (or bench) uses master.
interface decode_writeback_if;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        Cnd;
  logic        wb_en;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [2:0]  stat;
  logic [63:0] retired;

  modport master (
    output icode, ifun, rA, rB, valE, valM, Cnd, wb_en,
    input  srcA, srcB, dstE, dstM, valA, valB, stat, retired
  );

  modport slave (
    input  icode, ifun, rA, rB, valE, valM, Cnd, wb_en,
    output srcA, srcB, dstE, dstM, valA, valB, stat, retired
  );
endinterface

// File: rtl/regfile_core.sv
// Fifteen 64-bit program registers: two combinational read ports, two write
// ports with the M port winning on a shared destination. ID 4'hF reads 0.
module regfile_core
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_RESET = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  rd_addr_a,
  input  logic [3:0]  rd_addr_b,
  output logic [63:0] rd_data_a,
  output logic [63:0] rd_data_b,
  input  logic        we_e,
  input  logic [3:0]  dst_e,
  input  logic [63:0] data_e,
  input  logic        we_m,
  input  logic [3:0]  dst_m,
  input  logic [63:0] data_m
);

  logic [63:0] regs_q [15];
  logic [63:0] regs_d [15];

  always_comb begin
    for (int i = 0; i < 15; i++) regs_d[i] = regs_q[i];
    if (we_e && dst_e != RNONE) regs_d[dst_e] = data_e;
    // Applied last so popq %rsp keeps the popped value, not the bumped pointer.
    if (we_m && dst_m != RNONE) regs_d[dst_m] = data_m;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) regs_q[i] <= (i == int'(RRSP)) ? RSP_RESET : 64'h0;
    end else begin
      for (int i = 0; i < 15; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign rd_data_a = (rd_addr_a == RNONE) ? 64'h0 : regs_q[rd_addr_a];
  assign rd_data_b = (rd_addr_b == RNONE) ? 64'h0 : regs_q[rd_addr_b];

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode/write-back: register IDs, operand reads, retirement, status.
// Optional macro RF_BYPASS_EN forwards same-cycle write data to valA/valB (pipelined use only).
//
//   state | meaning
//   SAOK  | running; commits write back and count
//   SHLT  | halt retired; sticky until reset
//   SINS  | invalid icode retired; sticky until reset
module decode_writeback
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_RESET = 64'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  decode_writeback_if.slave  dwb
);

  stat_e       state_q, state_d;
  logic [63:0] retired_q, retired_d;
  logic [3:0]  src_a, src_b, dst_e, dst_m;
  logic [63:0] rf_a, rf_b;
  logic        commit, wr_en;
  logic        unused_ifun;

  assign unused_ifun = ^dwb.ifun;

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (dwb.icode)
      IRRMOVQ: begin src_a = dwb.rA; dst_e = dwb.Cnd ? dwb.rB : RNONE; end
      IIRMOVQ: dst_e = dwb.rB;
      IRMMOVQ: begin src_a = dwb.rA; src_b = dwb.rB; end
      IMRMOVQ: begin src_b = dwb.rB; dst_m = dwb.rA; end
      IOPQ:    begin src_a = dwb.rA; src_b = dwb.rB; dst_e = dwb.rB; end
      ICALL:   begin src_b = RRSP; dst_e = RRSP; end
      IRET:    begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; end
      IPUSHQ:  begin src_a = dwb.rA; src_b = RRSP; dst_e = RRSP; end
      IPOPQ:   begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; dst_m = dwb.rA; end
      default: ;
    endcase
  end

  assign commit = dwb.wb_en && (state_q == SAOK);
  // The halting or faulting instruction retires but must not touch the registers.
  assign wr_en  = commit && (dwb.icode != IHALT) && (dwb.icode <= IPOPQ);

  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    if (commit) begin
      retired_d = retired_q + 64'd1;
      if (dwb.icode == IHALT)     state_d = SHLT;
      else if (dwb.icode > IPOPQ) state_d = SINS;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= SAOK;
      retired_q <= 64'h0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  regfile_core #(.RSP_RESET(RSP_RESET)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (src_a),
    .rd_addr_b (src_b),
    .rd_data_a (rf_a),
    .rd_data_b (rf_b),
    .we_e      (wr_en),
    .dst_e     (dst_e),
    .data_e    (dwb.valE),
    .we_m      (wr_en),
    .dst_m     (dst_m),
    .data_m    (dwb.valM)
  );

`ifdef RF_BYPASS_EN
  always_comb begin
    dwb.valA = rf_a;
    dwb.valB = rf_b;
    if (wr_en) begin
      if (src_a != RNONE && src_a == dst_m)      dwb.valA = dwb.valM;
      else if (src_a != RNONE && src_a == dst_e) dwb.valA = dwb.valE;
      if (src_b != RNONE && src_b == dst_m)      dwb.valB = dwb.valM;
      else if (src_b != RNONE && src_b == dst_e) dwb.valB = dwb.valE;
    end
  end
`else
  assign dwb.valA = rf_a;
  assign dwb.valB = rf_b;
`endif

  assign dwb.srcA    = src_a;
  assign dwb.srcB    = src_b;
  assign dwb.dstE    = dst_e;
  assign dwb.dstM    = dst_m;
  assign dwb.stat    = state_q;
  assign dwb.retired = retired_q;

endmodule

// File: tb/tb_decode_writeback.sv
// Scoreboard bench for decode_writeback: stimulus queues expectations, a
// negedge monitor pops and compares them against the live outputs.
module tb_decode_writeback;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_writeback_if bus ();

  decode_writeback #(.RSP_RESET(64'h100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dwb   (bus)
  );

  typedef enum int {S_VALA, S_VALB, S_SRCA, S_SRCB, S_DSTE, S_DSTM, S_STAT, S_RET} sel_e;
  typedef struct {
    sel_e        sel;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  function automatic logic [63:0] pick(sel_e s);
    case (s)
      S_VALA: return bus.valA;
      S_VALB: return bus.valB;
      S_SRCA: return {60'h0, bus.srcA};
      S_SRCB: return {60'h0, bus.srcB};
      S_DSTE: return {60'h0, bus.dstE};
      S_DSTM: return {60'h0, bus.dstM};
      S_STAT: return {61'h0, bus.stat};
      default: return bus.retired;
    endcase
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [63:0] act;
      e = exp_q.pop_front();
      act = pick(e.sel);
      n_cmp++;
      if (act !== e.val) begin
        n_mis++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic expect_val(sel_e s, logic [63:0] v, string name);
    exp_t e;
    e.sel = s; e.val = v; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic drive(logic [3:0] ic, logic [3:0] ra, logic [3:0] rb,
                       logic [63:0] ve, logic [63:0] vm, logic cnd, logic wb);
    bus.icode = ic; bus.ifun = 4'h0; bus.rA = ra; bus.rB = rb;
    bus.valE = ve; bus.valM = vm; bus.Cnd = cnd; bus.wb_en = wb;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state seen through a ret decode (both sources = %rsp)
    drive(4'h9, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0);
    expect_val(S_SRCB, 64'h4,   "ret_srcB");
    expect_val(S_VALB, 64'h100, "reset_rsp");
    expect_val(S_STAT, 64'h1,   "reset_stat");
    expect_val(S_RET,  64'h0,   "reset_retired");
    step();

    // irmovq $0x1234, %rdx
    drive(4'h3, 4'hF, 4'h2, 64'h1234, 64'h0, 1'b0, 1'b1);
    expect_val(S_DSTE, 64'h2, "irmov_dstE");
    expect_val(S_DSTM, 64'hF, "irmov_dstM");
    expect_val(S_SRCA, 64'hF, "irmov_srcA");
    step();
    drive(4'h6, 4'h2, 4'h3, 64'h0, 64'h0, 1'b0, 1'b0);
    expect_val(S_VALA, 64'h1234, "opq_valA_after_irmov");
    expect_val(S_VALB, 64'h0,    "opq_valB_reg3");
    expect_val(S_RET,  64'h1,    "retired_1");
    step();

    // cmovXX %rdx, %rbp with Cnd=0 then Cnd=1
    drive(4'h2, 4'h2, 4'h5, 64'h7, 64'h0, 1'b0, 1'b1);
    bus.ifun = 4'h3;
    expect_val(S_DSTE, 64'hF, "cmov_nc_dstE");
    expect_val(S_SRCA, 64'h2, "cmov_srcA");
    step();
    drive(4'h6, 4'h5, 4'h5, 64'h0, 64'h0, 1'b0, 1'b0);
    expect_val(S_VALA, 64'h0, "cmov_nc_reg5");
    step();
    drive(4'h2, 4'h2, 4'h5, 64'h7, 64'h0, 1'b1, 1'b1);
    expect_val(S_DSTE, 64'h5, "cmov_c_dstE");
    step();
    drive(4'h6, 4'h5, 4'h5, 64'h0, 64'h0, 1'b0, 1'b0);
    expect_val(S_VALA, 64'h7, "cmov_c_reg5");
    expect_val(S_RET,  64'h3, "retired_3");
    step();

    // popq %rsp: valM must beat valE
    drive(4'hB, 4'h4, 4'hF, 64'h108, 64'hAA, 1'b0, 1'b1);
    expect_val(S_DSTE, 64'h4,   "popq_dstE");
    expect_val(S_DSTM, 64'h4,   "popq_dstM");
    expect_val(S_VALA, 64'h100, "popq_valA");
    step();
    drive(4'h9, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0);
    expect_val(S_VALB, 64'hAA, "popq_rsp_result");
    expect_val(S_RET,  64'h4,  "retired_4");
    step();

    // halt, then an ignored irmovq
    drive(4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b1);
    step();
    drive(4'h6, 4'h2, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0);
    expect_val(S_STAT, 64'h2, "halt_stat");
    expect_val(S_RET,  64'h5, "halt_retired");
    step();
    drive(4'h3, 4'hF, 4'h2, 64'h9999, 64'h0, 1'b0, 1'b1);
    step();
    drive(4'h6, 4'h2, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0);
    expect_val(S_VALA, 64'h1234, "hlt_no_write");
    expect_val(S_RET,  64'h5,    "hlt_no_count");
    expect_val(S_STAT, 64'h2,    "hlt_sticky");
    step();

    // Reset collides with a commit
    rst_n = 1'b0;
    drive(4'h3, 4'hF, 4'h2, 64'h55, 64'h0, 1'b0, 1'b1);
    step();
    rst_n = 1'b1;
    drive(4'h6, 4'h2, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0);
    expect_val(S_VALA, 64'h0, "rst_discards_write");
    expect_val(S_RET,  64'h0, "rst_retired");
    expect_val(S_STAT, 64'h1, "rst_stat");
    step();

    // Back-to-back commits to the same register
    drive(4'h3, 4'hF, 4'h3, 64'h11, 64'h0, 1'b0, 1'b1);
    step();
    drive(4'h3, 4'hF, 4'h3, 64'h22, 64'h0, 1'b0, 1'b1);
    step();
    drive(4'h6, 4'hF, 4'h3, 64'h0, 64'h0, 1'b0, 1'b0);
    expect_val(S_VALB, 64'h22, "b2b_last_wins");
    expect_val(S_RET,  64'h2,  "b2b_retired");
    step();

    // Invalid instruction
    drive(4'hC, 4'hF, 4'h3, 64'h33, 64'h0, 1'b0, 1'b1);
    step();
    drive(4'h3, 4'hF, 4'h3, 64'h44, 64'h0, 1'b0, 1'b1);
    expect_val(S_STAT, 64'h4, "ins_stat");
    expect_val(S_RET,  64'h3, "ins_retired");
    step();
    drive(4'h6, 4'hF, 4'h3, 64'h0, 64'h0, 1'b0, 1'b0);
    expect_val(S_VALB, 64'h22, "ins_no_write");
    expect_val(S_RET,  64'h3,  "ins_no_count");
    expect_val(S_STAT, 64'h4,  "ins_sticky");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
